// File: rtl/qfix_pkg.sv
// Shared definitions for the sign-magnitude fixed-point (N, Q) datapath stages.
// Defaults, divider FSM states and small constant helpers; no logic of its own.
package qfix_pkg;

    localparam int QFIX_Q = 15;
    localparam int QFIX_N = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } qdiv_state_t;

    // Largest positive sign-magnitude value {1'b0, all ones}, caller narrows to N bits.
    function automatic logic [63:0] qfix_sat(input int n);
        return (64'd1 << (n - 1)) - 64'd1;
    endfunction

    function automatic int qfix_iters(input int n, input int q);
        return n + q - 1;
    endfunction

endpackage

// File: rtl/qdiv_step.sv
// One restoring-division step: shift a numerator bit into the remainder, subtract if it fits.
// Purely combinational; the caller owns all state and flow control.
module qdiv_step #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_rem,
    input  logic         i_bit,
    input  logic [N-2:0] i_div,
    output logic [N-1:0] o_rem,
    output logic         o_qbit
);

    logic [N:0] w_sh;
    logic [N:0] w_div;

    always_comb begin
        w_sh  = {i_rem, i_bit};
        w_div = {2'b00, i_div};
        if (w_sh >= w_div) begin
            o_qbit = 1'b1;
            o_rem  = N'(w_sh - w_div);
        end else begin
            o_qbit = 1'b0;
            o_rem  = w_sh[N-1:0];
        end
    end

endmodule

// File: rtl/qdiv.sv
// Sequential sign-magnitude Q-format divider, one quotient bit per clock, N+Q-1 cycle latency.
// start/done handshake: i_start is ignored while busy; results hold until the next completion.
module qdiv
    import qfix_pkg::*;
#(
    parameter int Q = QFIX_Q,
    parameter int N = QFIX_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    input  logic         i_ovr,
    output logic         o_busy,
    output logic         o_done,
    output logic [N-1:0] o_quotient,
    output logic         o_ovr,
    output logic         o_dbz
);

    localparam int NW = N - 1 + Q;
    localparam int CW = $clog2(N + Q);
    localparam logic [N-1:0]  SAT   = N'(qfix_sat(N));
    localparam logic [CW-1:0] ITERS = CW'(qfix_iters(N, Q));

    qdiv_state_t r_state;
    qdiv_state_t w_state_nxt;

    logic          r_sign;
    logic          r_iovr;
    logic          r_dbz;
    logic [NW-1:0] r_num;
    logic [NW-2:0] r_quo;
    logic [N-1:0]  r_rem;
    logic [N-2:0]  r_div;
    logic [CW-1:0] r_cnt;

    logic          r_busy;
    logic          r_done;
    logic [N-1:0]  r_q;
    logic          r_ovr;
    logic          r_dbz_o;

    logic          w_accept;
    logic          w_last;
    logic          w_qbit;
    logic [N-1:0]  w_rem_nxt;
    logic [NW-1:0] w_raw_nxt;
    logic          w_sat;
    logic [N-2:0]  w_mag;
    logic          w_sign;
    logic [N-1:0]  w_res_q;
    logic          w_res_ovr;
    logic          w_res_dbz;
    logic          w_busy_nxt;

    assign w_accept = i_start && (r_state != RUN);
    assign w_last   = (r_state == RUN) && (r_dbz || (r_cnt == CW'(1)));

    qdiv_step #(.N(N)) u_step (
        .i_rem  (r_rem),
        .i_bit  (r_num[NW-1]),
        .i_div  (r_div),
        .o_rem  (w_rem_nxt),
        .o_qbit (w_qbit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_nxt = RUN;
            RUN:     if (w_last)  w_state_nxt = DONE;
            DONE:    w_state_nxt = i_start ? RUN : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Result is formed from the final step so it can be registered on the same edge.
    always_comb begin
        w_raw_nxt = {r_quo, w_qbit};
        w_sat     = |w_raw_nxt[NW-1:N-1];
        if (r_dbz) begin
            w_mag     = SAT[N-2:0];
            w_sign    = r_sign & (|r_num);
            w_res_ovr = 1'b1;
            w_res_dbz = 1'b1;
        end else begin
            w_mag     = w_sat ? SAT[N-2:0] : w_raw_nxt[N-2:0];
            w_sign    = r_sign & (|w_mag);
            w_res_ovr = w_sat | r_iovr;
            w_res_dbz = 1'b0;
        end
        w_res_q    = {w_sign, w_mag};
        w_busy_nxt = (w_state_nxt == RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sign  <= 1'b0;
            r_iovr  <= 1'b0;
            r_dbz   <= 1'b0;
            r_num   <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_div   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_q     <= '0;
            r_ovr   <= 1'b0;
            r_dbz_o <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sign <= i_dividend[N-1] ^ i_divisor[N-1];
                r_iovr <= i_ovr;
                r_dbz  <= (i_divisor[N-2:0] == '0);
                r_num  <= {i_dividend[N-2:0], {Q{1'b0}}};
                r_div  <= i_divisor[N-2:0];
                r_quo  <= '0;
                r_rem  <= '0;
                r_cnt  <= ITERS;
            end else if ((r_state == RUN) && !r_dbz) begin
                r_num <= {r_num[NW-2:0], 1'b0};
                r_quo <= w_raw_nxt[NW-2:0];
                r_rem <= w_rem_nxt;
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_last) begin
                r_q     <= w_res_q;
                r_ovr   <= w_res_ovr;
                r_dbz_o <= w_res_dbz;
            end
            r_done <= w_last;
            r_busy <= w_busy_nxt;
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_quotient = r_q;
    assign o_ovr      = r_ovr;
    assign o_dbz      = r_dbz_o;

endmodule
